mp3_header_sync: RTL and testbench
==================================

MP3_HEADER_SYNC -- requirements
Module: mp3_header_sync

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 axiiv  input  1  byte valid from SD reader; one byte accepted per cycle where high.
REQ-004 axiid  input  8  byte from SD reader, MSB first in bitstream order.
REQ-005 valid_header  output  1  one-cycle pulse: a complete valid MPEG-1 Layer III header was just accepted.
REQ-006 mode  output  2  channel mode from header byte 3 bits [7:6]; held until next valid header.
REQ-007 prot  output  1  protection bit from header byte 1 bit 0 (1 = no CRC); held.
REQ-008 frame_size  output  11  total frame length in bytes including header; held.
REQ-009 sync_lost  output  1  one-cycle pulse: expected sync absent at the byte following a skipped frame.

Function
REQ-010 States SHALL be HUNT, SYNC1, HDR2, HDR3, SKIP; only bytes with axiiv=1 cause transitions or counting.
REQ-011 HUNT: byte 0xFF -> SYNC1; other bytes stay in HUNT.
REQ-012 SYNC1: byte[7:1]==7'b1111101 (sync tail, MPEG-1, Layer III) -> HDR2, latch prot=byte[0]; byte 0xFF stays in SYNC1; else -> HUNT.
REQ-013 HDR2: bitrate_idx=byte[7:4], sr_idx=byte[3:2], pad=byte[1]; bitrate_idx 0 or 15, or sr_idx 3 -> HUNT (SYNC1 if byte is 0xFF); else latch fields -> HDR3.
REQ-014 HDR3: any byte accepted; latch mode=byte[7:6]; -> SKIP; valid_header=1 in the following cycle only.
REQ-015 mode, prot, frame_size SHALL update in the same cycle valid_header rises and never otherwise; HDR2 latches are internal shadows.
REQ-016 Bitrates (kbps) for idx 1..14: 32,40,48,56,64,80,96,112,128,160,192,224,256,320; sample rates idx 0/1/2: 44100/48000/32000 Hz.
REQ-017 frame_size SHALL equal floor(144000*kbps/Hz)+pad, from a 14x3 constant table plus pad; no runtime divider.
REQ-018 On HDR3 acceptance, skip counter SHALL load frame_size-4; in SKIP each accepted byte decrements it; bytes in SKIP never trigger sync detection.
REQ-019 When counter reaches 0, state -> HUNT-with-expectation: next accepted byte 0xFF -> SYNC1; otherwise sync_lost pulses the following cycle and state -> HUNT.
REQ-020 Latency: valid_header high exactly one cycle after the edge accepting header byte 3 (4th byte).
REQ-021 System constraint: SD reader never asserts axiiv on consecutive cycles, so the downstream demultiplexer sees valid_header before the first post-header byte.
REQ-022 valid_header and sync_lost SHALL never be high in the same cycle.
REQ-023 axiiv=0 SHALL hold state, counter and all latches unchanged.

Reset
REQ-024 rst=1 at any edge SHALL force state HUNT, counter 0, valid_header=0, sync_lost=0, mode=0, prot=0, frame_size=0, discarding partial headers.
REQ-025 Reset has priority over a byte accepted in the same cycle; that byte is dropped.

Verification
REQ-026 Bytes FF FB 90 44 -> valid_header 1 cycle after 4th byte, prot=1, mode=01, frame_size=417; next 413 bytes skipped.
REQ-027 Bytes FF FA 92 C0 -> prot=0, mode=11, frame_size=418 (padded, 128k/44.1k).
REQ-028 Bytes 00 FF FF FB 94 00 -> frame_size=384 (128k/48k); the repeated FF stays in SYNC1.
REQ-029 FF FB F0 00 and FF FB 9C 00 -> no valid_header; FF FB 00 FF FB 90 00 -> one header on the second sync.
REQ-030 Frame at 417 containing FF FB 90 44 inside payload -> no extra valid_header; byte 0x12 after the 413-byte skip -> sync_lost pulse.
REQ-031 rst asserted after FF FB 90 -> outputs zero; resume with 44 -> no header; then FF FB 90 44 -> valid header.

Source files
------------

// File: rtl/mp3_header_sync.sv
// mp3_header_sync: locks onto MPEG-1 Layer III frame headers in a byte stream.
// A header is FF, {7'b1111101, prot}, {bitrate, srate, pad, priv}, {mode, ...}.
// Once a header is accepted the frame payload is skipped by length, and the
// byte right after the frame must start the next sync word.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   axiiv        byte valid (one byte per cycle where high)
//   axiid        byte, MSB first in bitstream order
//   valid_header one-cycle pulse after the 4th header byte is accepted
//   mode         channel mode of the last valid header
//   prot         protection bit of the last valid header (1 = no CRC)
//   frame_size   total frame length in bytes, header included
//   sync_lost    one-cycle pulse when a frame is not followed by a sync byte
module mp3_header_sync (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [7:0]  axiid,
  output logic        valid_header,
  output logic [1:0]  mode,
  output logic        prot,
  output logic [10:0] frame_size,
  output logic        sync_lost
);

  typedef enum logic [2:0] {
    StHunt,
    StSync1,
    StHdr2,
    StHdr3,
    StSkip
  } state_e;

  state_e      state_q, state_d;
  logic        expect_q, expect_d;    // HUNT with a sync byte due next
  logic [10:0] cnt_q, cnt_d;
  logic        prot_sh_q, prot_sh_d;  // header fields not yet published
  logic [3:0]  br_sh_q, br_sh_d;
  logic [1:0]  sr_sh_q, sr_sh_d;
  logic        pad_sh_q, pad_sh_d;
  logic        valid_header_q, valid_header_d;
  logic        sync_lost_q, sync_lost_d;
  logic [1:0]  mode_q, mode_d;
  logic        prot_q, prot_d;
  logic [10:0] frame_size_q, frame_size_d;

  logic [10:0] fs_new;
  logic        byte_ff;
  logic [3:0]  br_in;
  logic [1:0]  sr_in;

  // floor(144000 * kbps / Hz) for each bitrate index and sample-rate index.
  function automatic logic [10:0] frame_base(input logic [3:0] br, input logic [1:0] sr);
    logic [10:0] f44, f48, f32;
    case (br)
      4'd1:    begin f44 = 11'd104;  f48 = 11'd96;  f32 = 11'd144;  end
      4'd2:    begin f44 = 11'd130;  f48 = 11'd120; f32 = 11'd180;  end
      4'd3:    begin f44 = 11'd156;  f48 = 11'd144; f32 = 11'd216;  end
      4'd4:    begin f44 = 11'd182;  f48 = 11'd168; f32 = 11'd252;  end
      4'd5:    begin f44 = 11'd208;  f48 = 11'd192; f32 = 11'd288;  end
      4'd6:    begin f44 = 11'd261;  f48 = 11'd240; f32 = 11'd360;  end
      4'd7:    begin f44 = 11'd313;  f48 = 11'd288; f32 = 11'd432;  end
      4'd8:    begin f44 = 11'd365;  f48 = 11'd336; f32 = 11'd504;  end
      4'd9:    begin f44 = 11'd417;  f48 = 11'd384; f32 = 11'd576;  end
      4'd10:   begin f44 = 11'd522;  f48 = 11'd480; f32 = 11'd720;  end
      4'd11:   begin f44 = 11'd626;  f48 = 11'd576; f32 = 11'd864;  end
      4'd12:   begin f44 = 11'd731;  f48 = 11'd672; f32 = 11'd1008; end
      4'd13:   begin f44 = 11'd835;  f48 = 11'd768; f32 = 11'd1152; end
      4'd14:   begin f44 = 11'd1044; f48 = 11'd960; f32 = 11'd1440; end
      default: begin f44 = 11'd0;    f48 = 11'd0;   f32 = 11'd0;    end
    endcase
    case (sr)
      2'd0:    frame_base = f44;
      2'd1:    frame_base = f48;
      default: frame_base = f32;
    endcase
  endfunction

  assign fs_new  = frame_base(br_sh_q, sr_sh_q) + {10'd0, pad_sh_q};
  assign byte_ff = (axiid == 8'hFF);
  assign br_in   = axiid[7:4];
  assign sr_in   = axiid[3:2];

  always_comb begin
    state_d        = state_q;
    expect_d       = expect_q;
    cnt_d          = cnt_q;
    prot_sh_d      = prot_sh_q;
    br_sh_d        = br_sh_q;
    sr_sh_d        = sr_sh_q;
    pad_sh_d       = pad_sh_q;
    valid_header_d = 1'b0;
    sync_lost_d    = 1'b0;
    mode_d         = mode_q;
    prot_d         = prot_q;
    frame_size_d   = frame_size_q;

    if (axiiv) begin
      case (state_q)
        StHunt: begin
          expect_d = 1'b0;
          if (byte_ff) begin
            state_d = StSync1;
          end else if (expect_q) begin
            sync_lost_d = 1'b1;
          end
        end
        StSync1: begin
          if (axiid[7:1] == 7'b1111101) begin
            state_d   = StHdr2;
            prot_sh_d = axiid[0];
          end else if (!byte_ff) begin
            state_d = StHunt;
          end
        end
        StHdr2: begin
          if (br_in == 4'd0 || br_in == 4'd15 || sr_in == 2'd3) begin
            // A rejected FF byte may itself be the start of the real sync.
            state_d = byte_ff ? StSync1 : StHunt;
          end else begin
            br_sh_d  = br_in;
            sr_sh_d  = sr_in;
            pad_sh_d = axiid[1];
            state_d  = StHdr3;
          end
        end
        StHdr3: begin
          state_d        = StSkip;
          valid_header_d = 1'b1;
          mode_d         = axiid[7:6];
          prot_d         = prot_sh_q;
          frame_size_d   = fs_new;
          cnt_d          = fs_new - 11'd4;
        end
        StSkip: begin
          cnt_d = cnt_q - 11'd1;
          if (cnt_q <= 11'd1) begin
            cnt_d    = 11'd0;
            state_d  = StHunt;
            expect_d = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHunt;
      expect_q       <= 1'b0;
      cnt_q          <= 11'd0;
      prot_sh_q      <= 1'b0;
      br_sh_q        <= 4'd0;
      sr_sh_q        <= 2'd0;
      pad_sh_q       <= 1'b0;
      valid_header_q <= 1'b0;
      sync_lost_q    <= 1'b0;
      mode_q         <= 2'd0;
      prot_q         <= 1'b0;
      frame_size_q   <= 11'd0;
    end else begin
      state_q        <= state_d;
      expect_q       <= expect_d;
      cnt_q          <= cnt_d;
      prot_sh_q      <= prot_sh_d;
      br_sh_q        <= br_sh_d;
      sr_sh_q        <= sr_sh_d;
      pad_sh_q       <= pad_sh_d;
      valid_header_q <= valid_header_d;
      sync_lost_q    <= sync_lost_d;
      mode_q         <= mode_d;
      prot_q         <= prot_d;
      frame_size_q   <= frame_size_d;
    end
  end

  assign valid_header = valid_header_q;
  assign sync_lost    = sync_lost_q;
  assign mode         = mode_q;
  assign prot         = prot_q;
  assign frame_size   = frame_size_q;

endmodule

// File: tb/tb_mp3_header_sync.sv
// Bench for mp3_header_sync. The reference model sees the byte stream as a
// sliding 4-byte window: outside a frame payload, the newest four bytes form a
// header exactly when they match the MPEG-1 Layer III header pattern; frame
// length comes from plain arithmetic on bitrate and sample rate.
module tb_mp3_header_sync;

  logic        clk;
  logic        rst;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        valid_header;
  logic [1:0]  mode;
  logic        prot;
  logic [10:0] frame_size;
  logic        sync_lost;

  mp3_header_sync dut (
    .clk          (clk),
    .rst          (rst),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .valid_header (valid_header),
    .mode         (mode),
    .prot         (prot),
    .frame_size   (frame_size),
    .sync_lost    (sync_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int vh_count = 0;
  bit chk_en   = 1'b0;

  int kbps_tab [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
  int hz_tab   [4]  = '{44100, 48000, 32000, 0};

  // Model state.
  int         m_skip   = 0;
  bit         m_expect = 1'b0;
  int         m_n      = 0;
  logic [7:0] w [4];
  logic       nxt_vh = 1'b0, nxt_sl = 1'b0, nxt_prot = 1'b0;
  logic [1:0] nxt_mode = 2'd0;
  int         nxt_fs = 0;
  logic       cur_vh = 1'b0, cur_sl = 1'b0, cur_prot = 1'b0;
  logic [1:0] cur_mode = 2'd0;
  int         cur_fs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int br, sr;
    nxt_vh = 1'b0;
    nxt_sl = 1'b0;
    if (r) begin
      m_skip   = 0;
      m_expect = 1'b0;
      m_n      = 0;
      nxt_mode = 2'd0;
      nxt_prot = 1'b0;
      nxt_fs   = 0;
    end else if (v) begin
      if (m_skip > 0) begin
        m_skip--;
        if (m_skip == 0) m_expect = 1'b1;
      end else begin
        if (m_expect) begin
          m_expect = 1'b0;
          if (d != 8'hFF) nxt_sl = 1'b1;
        end
        w[0] = w[1];
        w[1] = w[2];
        w[2] = w[3];
        w[3] = d;
        if (m_n < 4) m_n++;
        br = int'(w[2][7:4]);
        sr = int'(w[2][3:2]);
        if (m_n == 4 && w[0] == 8'hFF && w[1][7:1] == 7'b1111101 &&
            br != 0 && br != 15 && sr != 3) begin
          nxt_vh   = 1'b1;
          nxt_prot = w[1][0];
          nxt_mode = w[3][7:6];
          nxt_fs   = (144000 * kbps_tab[br]) / hz_tab[sr] + int'(w[2][1]);
          m_skip   = nxt_fs - 4;
          m_n      = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst   = r;
    axiiv = v;
    axiid = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    cur_vh   = nxt_vh;
    cur_sl   = nxt_sl;
    cur_prot = nxt_prot;
    cur_mode = nxt_mode;
    cur_fs   = nxt_fs;
  endtask

  // Idle cycles drive FF on the data bus so an ignored axiiv would show up.
  task automatic idle();
    step(1'b0, 1'b0, 8'hFF);
  endtask

  task automatic send_raw(input logic [7:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_raw(d);
    idle();
  endtask

  // Sends a 4-byte header; literal checks right after the 4th byte's edge.
  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int fs, input logic p,
                          input logic [1:0] md, input string tag);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_raw(b3);
    check({tag, "_vh"}, 32'(valid_header), 32'd1);
    check({tag, "_fs"}, 32'(frame_size), 32'(fs));
    check({tag, "_prot"}, 32'(prot), 32'(p));
    check({tag, "_mode"}, 32'(mode), 32'(md));
    idle();
  endtask

  task automatic skip_payload(input int n);
    logic [7:0] p [4];
    p = '{8'hFF, 8'hFB, 8'h90, 8'h44};
    for (int i = 0; i < n; i++) begin
      if (i < 4) send_byte(p[i]);
      else send_byte(8'(i * 37));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("vh", 32'(valid_header), 32'(cur_vh));
      check("sync_lost", 32'(sync_lost), 32'(cur_sl));
      check("mode", 32'(mode), 32'(cur_mode));
      check("prot", 32'(prot), 32'(cur_prot));
      check("frame_size", 32'(frame_size), 32'(cur_fs));
      check("vh_sl_excl", 32'(valid_header & sync_lost), 32'd0);
      if (valid_header === 1'b1) vh_count++;
    end
  end

  initial begin
    int saved;
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    check("rst_vh", 32'(valid_header), 32'd0);
    check("rst_fs", 32'(frame_size), 32'd0);
    check("rst_sl", 32'(sync_lost), 32'd0);
    idle();

    // 128k/44.1k, no pad, payload holding a fake header.
    send_hdr(8'hFF, 8'hFB, 8'h90, 8'h44, 417, 1'b1, 2'd1, "h417");
    saved = vh_count;
    skip_payload(413);
    check("payload_no_hdr", 32'(vh_count), 32'(saved));

    // Next frame starts right on time: padded 128k/44.1k.
    send_hdr(8'hFF, 8'hFA, 8'h92, 8'hC0, 418, 1'b0, 2'd3, "h418");
    skip_payload(414);
    send_raw(8'h12);
    check("sync_lost_pulse", 32'(sync_lost), 32'd1);
    check("mode_held", 32'(mode), 32'd3);
    idle();
    check("sync_lost_one_cycle", 32'(sync_lost), 32'd0);

    // Leading junk and repeated FF.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_hdr(8'hFF, 8'hFB, 8'h94, 8'h00, 384, 1'b1, 2'd0, "h384");
    skip_payload(380);
    send_byte(8'h00);

    // Bad bitrate index 15 and bad sample-rate index 3.
    saved = vh_count;
    send_byte(8'hFF); send_byte(8'hFB); send_byte(8'hF0); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'hFB); send_byte(8'h9C); send_byte(8'h00);
    check("bad_idx_no_hdr", 32'(vh_count), 32'(saved));

    // Bitrate 0 aborts; header found on the second sync.
    send_byte(8'hFF); send_byte(8'hFB); send_byte(8'h00);
    send_hdr(8'hFF, 8'hFB, 8'h90, 8'h00, 417, 1'b1, 2'd0, "resync");
    check("resync_one_hdr", 32'(vh_count), 32'(saved + 1));
    skip_payload(413);

    // Reset mid-header, with a byte presented in the reset cycle.
    send_byte(8'hFF); send_byte(8'hFB); send_byte(8'h90);
    step(1'b1, 1'b1, 8'h44);
    check("rst_mid_vh", 32'(valid_header), 32'd0);
    check("rst_mid_fs", 32'(frame_size), 32'd0);
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_prot", 32'(prot), 32'd0);
    idle();
    saved = vh_count;
    send_byte(8'h44);
    check("partial_dropped", 32'(vh_count), 32'(saved));
    send_hdr(8'hFF, 8'hFB, 8'h90, 8'h44, 417, 1'b1, 2'd1, "after_rst");

    // 320k/48k padded.
    step(1'b1, 1'b0, 8'h00);
    send_hdr(8'hFF, 8'hFB, 8'hE6, 8'h80, 961, 1'b1, 2'd2, "h961");

    // Full table sweep; reset between headers to skip the payload.
    for (int br = 1; br <= 14; br++) begin
      for (int sr = 0; sr <= 2; sr++) begin
        for (int pd = 0; pd <= 1; pd++) begin
          step(1'b1, 1'b0, 8'h00);
          send_byte(8'hFF);
          send_byte(8'hFB);
          send_byte({4'(br), 2'(sr), 1'(pd), 1'b0});
          send_byte(8'h40);
        end
      end
    end
    check("sweep_count", 32'(vh_count), 32'(saved + 2 + 84));
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
